// File: rtl/hue_pkg.sv
// rtl/hue_pkg.sv - shared types and helpers for the hue sequencer
package hue_pkg;

    typedef enum logic [2:0] {
        SEC_RY = 3'd0,
        SEC_YG = 3'd1,
        SEC_GC = 3'd2,
        SEC_CB = 3'd3,
        SEC_BM = 3'd4,
        SEC_MR = 3'd5
    } sector_t;

    localparam int SECTOR_W = 3;

    function automatic int duty_width(input int interval);
        return $clog2(interval + 1);
    endfunction

    function automatic sector_t next_sector(input sector_t s);
        return (s == SEC_MR) ? SEC_RY : sector_t'(s + 3'd1);
    endfunction

    function automatic sector_t prev_sector(input sector_t s);
        return (s == SEC_RY) ? SEC_MR : sector_t'(s - 3'd1);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - enable-gated prescaler producing one tick every TICK_CYCLES enabled clocks
module tick_gen #(
    parameter int TICK_CYCLES = 1667
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    // a one-bit counter that never leaves 0 keeps TICK_CYCLES=1 legal
    localparam int PCW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PCW-1:0] PC_LAST = PCW'(TICK_CYCLES - 1);

    logic [PCW-1:0] pc;

    assign tick = en && (pc == PC_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
        end else if (tick) begin
            pc <= '0;
        end else if (en) begin
            pc <= pc + PCW'(1);
        end
    end

endmodule

// File: rtl/hue_sequencer.sv
// rtl/hue_sequencer.sv - sweeps RGB duty words around the HSV hue circle in six linear sectors
module hue_sequencer
    import hue_pkg::*;
#(
    parameter int PWM_INTERVAL = 1200,
    parameter int TICK_CYCLES  = 1667
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en,
    input  logic                                  dir,
    output logic [duty_width(PWM_INTERVAL)-1:0]   pwm_valueR,
    output logic [duty_width(PWM_INTERVAL)-1:0]   pwm_valueG,
    output logic [duty_width(PWM_INTERVAL)-1:0]   pwm_valueB,
    output logic [SECTOR_W-1:0]                   sector,
    output logic                                  wrap
);

    localparam int W = duty_width(PWM_INTERVAL);
    localparam logic [W-1:0] FULL   = W'(PWM_INTERVAL);
    localparam logic [W-1:0] R_LAST = W'(PWM_INTERVAL - 1);

    logic         tick;
    sector_t      s, s_next;
    logic [W-1:0] r, r_next;
    logic         wrap_evt, wrap_evt_next;
    logic [W-1:0] duty_r, duty_g, duty_b;
    logic [W-1:0] up, down;

    tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .tick(tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s        <= SEC_RY;
            r        <= '0;
            wrap_evt <= 1'b0;
        end else begin
            s        <= s_next;
            r        <= r_next;
            wrap_evt <= wrap_evt_next;
        end
    end

    always_comb begin
        s_next        = s;
        r_next        = r;
        wrap_evt_next = 1'b0;
        if (tick) begin
            if (!dir) begin
                if (r < R_LAST) begin
                    r_next = r + W'(1);
                end else begin
                    r_next        = '0;
                    s_next        = next_sector(s);
                    wrap_evt_next = (s == SEC_MR);
                end
            end else begin
                if (r != '0) begin
                    r_next = r - W'(1);
                end else begin
                    r_next        = R_LAST;
                    s_next        = prev_sector(s);
                    wrap_evt_next = (s == SEC_RY);
                end
            end
        end
    end

    // r never reaches FULL, so the falling ramp cannot underflow
    assign up   = r;
    assign down = FULL - r;

    always_comb begin
        duty_r = FULL;
        duty_g = '0;
        duty_b = '0;
        case (s)
            SEC_RY: begin duty_r = FULL; duty_g = up;   duty_b = '0;   end
            SEC_YG: begin duty_r = down; duty_g = FULL; duty_b = '0;   end
            SEC_GC: begin duty_r = '0;   duty_g = FULL; duty_b = up;   end
            SEC_CB: begin duty_r = '0;   duty_g = down; duty_b = FULL; end
            SEC_BM: begin duty_r = up;   duty_g = '0;   duty_b = FULL; end
            SEC_MR: begin duty_r = FULL; duty_g = '0;   duty_b = down; end
            default: begin duty_r = FULL; duty_g = '0; duty_b = '0;    end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_valueR <= FULL;
            pwm_valueG <= '0;
            pwm_valueB <= '0;
            sector     <= '0;
            wrap       <= 1'b0;
        end else begin
            pwm_valueR <= duty_r;
            pwm_valueG <= duty_g;
            pwm_valueB <= duty_b;
            sector     <= s;
            wrap       <= wrap_evt;
        end
    end

endmodule

// File: tb/tb_hue_sequencer.sv
// tb/tb_hue_sequencer.sv - directed checks of hue_sequencer with PWM_INTERVAL=4, TICK_CYCLES=3
module tb_hue_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic       dir = 1'b0;
    logic [2:0] pwm_r, pwm_g, pwm_b;
    logic [2:0] sector;
    logic       wrap;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       en;
        logic       dir;
        int         n;
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
        logic [2:0] sec;
        logic       wrap;
    } vec_t;

    vec_t vecs[12];

    hue_sequencer #(
        .PWM_INTERVAL(4),
        .TICK_CYCLES (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .dir       (dir),
        .pwm_valueR(pwm_r),
        .pwm_valueG(pwm_g),
        .pwm_valueB(pwm_b),
        .sector    (sector),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2:0] er, input logic [2:0] eg,
                         input logic [2:0] eb, input logic [2:0] es, input logic ew);
        checks++;
        if ({pwm_r, pwm_g, pwm_b, sector, wrap} !== {er, eg, eb, es, ew}) begin
            failures++;
            $display("FAIL %s: got R=%0d G=%0d B=%0d sector=%0d wrap=%0d, want R=%0d G=%0d B=%0d sector=%0d wrap=%0d",
                     name, pwm_r, pwm_g, pwm_b, sector, wrap, er, eg, eb, es, ew);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        en  = 1'b0;
        dir = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int wraps;
        int wrap_cycle;

        // running sequence: forward ramp, reversal across a boundary, freeze, resume
        vecs[0]  = '{1'b0, 1'b0, 3, 3'd4, 3'd0, 3'd0, 3'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 4, 3'd4, 3'd1, 3'd0, 3'd0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 3, 3'd4, 3'd2, 3'd0, 3'd0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 3, 3'd4, 3'd3, 3'd0, 3'd0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 3, 3'd4, 3'd4, 3'd0, 3'd1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 3, 3'd3, 3'd4, 3'd0, 3'd1, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 3, 3'd4, 3'd4, 3'd0, 3'd1, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 3, 3'd4, 3'd3, 3'd0, 3'd0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 3, 3'd4, 3'd2, 3'd0, 3'd0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 5, 3'd4, 3'd2, 3'd0, 3'd0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 2, 3'd4, 3'd2, 3'd0, 3'd0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1, 3'd4, 3'd3, 3'd0, 3'd0, 1'b0};

        #1 rst = 1'b1;
        #1 check("reset_async", 3'd4, 3'd0, 3'd0, 3'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        check("reset_release", 3'd4, 3'd0, 3'd0, 3'd0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            en  = vecs[i].en;
            dir = vecs[i].dir;
            cycles(vecs[i].n);
            check($sformatf("vec%0d", i), vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].sec, vecs[i].wrap);
        end

        // full revolution: exactly one wrap, one clock after tick 24
        do_reset();
        en = 1'b1;
        wraps = 0;
        wrap_cycle = -1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (wrap === 1'b1) begin
                wraps++;
                wrap_cycle = c;
                check("rev_wrap_state", 3'd4, 3'd0, 3'd0, 3'd0, 1'b1);
            end
        end
        check_int("rev_wrap_count", wraps, 1);
        check_int("rev_wrap_cycle", wrap_cycle, 73);

        // freeze at pc=1 with G=1
        do_reset();
        en = 1'b1;
        cycles(4);
        check("freeze_entry", 3'd4, 3'd1, 3'd0, 3'd0, 1'b0);
        en = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("freeze_hold%0d", c), 3'd4, 3'd1, 3'd0, 3'd0, 1'b0);
        end
        en = 1'b1;
        cycles(2);
        check("freeze_resume_pre", 3'd4, 3'd1, 3'd0, 3'd0, 1'b0);
        cycles(1);
        check("freeze_resume_tick", 3'd4, 3'd2, 3'd0, 3'd0, 1'b0);

        // reverse from reset wraps straight into sector 5
        do_reset();
        en  = 1'b1;
        dir = 1'b1;
        cycles(3);
        check("rev_pre_tick", 3'd4, 3'd0, 3'd0, 3'd0, 1'b0);
        cycles(1);
        check("rev_first_tick", 3'd4, 3'd0, 3'd1, 3'd5, 1'b1);
        cycles(1);
        check("rev_wrap_drop", 3'd4, 3'd0, 3'd1, 3'd5, 1'b0);

        // async reset mid sector 3, then first tick TICK_CYCLES clocks after release
        do_reset();
        en = 1'b1;
        cycles(40);
        check("sec3_state", 3'd0, 3'd3, 3'd4, 3'd3, 1'b0);
        #2 rst = 1'b1;
        #1 check("sec3_async_reset", 3'd4, 3'd0, 3'd0, 3'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cycles(3);
        check("post_reset_pre_tick", 3'd4, 3'd0, 3'd0, 3'd0, 1'b0);
        cycles(1);
        check("post_reset_tick", 3'd4, 3'd1, 3'd0, 3'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
